// File: rtl/mic_triplet_aligner.sv
// +----------------------------------------------------------------------------+
// | mic_triplet_aligner: gathers one sample per mic into aligned triplets      |
// | with arrival skew, sticky error flags and an output FIFO.  Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module mic_triplet_aligner #(
  parameter int WIDTH          = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SKEW_W         = 12
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [2:0]                    mic_valid_in,
  input  logic [WIDTH-1:0]              mic_data_0_in,
  input  logic [WIDTH-1:0]              mic_data_1_in,
  input  logic [WIDTH-1:0]              mic_data_2_in,
  input  logic                          clear_flags_in,
  input  logic                          out_ready_in,
  output logic                          out_valid_out,
  output logic [WIDTH-1:0]              out_data_0_out,
  output logic [WIDTH-1:0]              out_data_1_out,
  output logic [WIDTH-1:0]              out_data_2_out,
  output logic [SKEW_W-1:0]             out_skew_out,
  output logic [$clog2(FIFO_DEPTH):0]   fill_out,
  output logic                          timeout_flag_out,
  output logic                          dup_flag_out,
  output logic                          drop_flag_out
);

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int FILL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int E_W         = 3 * WIDTH + SKEW_W;
  localparam int SKEW_MAX_I  = (1 << SKEW_W) - 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          captured_q, captured_d;
  logic [WIDTH-1:0]    slot_q [3];
  logic [WIDTH-1:0]    slot_d [3];
  logic [SKEW_W-1:0]   set_skew_q, set_skew_d;

  logic [E_W-1:0]      mem_q [FIFO_DEPTH];
  logic [E_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [FILL_W-1:0]   fill_q, fill_d;

  logic timeout_q, timeout_d, dup_q, dup_d, drop_q, drop_d;

  logic [WIDTH-1:0]    mic_data [3];
  logic [CNT_W-1:0]    cnt_inc;
  logic [2:0]          cap_all;
  logic                push, timeout_set, dup_set, drop_set;
  logic                pop, full, do_push;

  assign mic_data[0] = mic_data_0_in;
  assign mic_data[1] = mic_data_1_in;
  assign mic_data[2] = mic_data_2_in;

  // Set assembly.  cnt_q holds the offset of the previous cycle from the first
  // capture, so cnt_inc is the offset of the current cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    captured_d  = captured_q;
    set_skew_d  = set_skew_q;
    for (int i = 0; i < 3; i++) slot_d[i] = slot_q[i];
    push        = 1'b0;
    timeout_set = 1'b0;
    dup_set     = 1'b0;
    cnt_inc     = cnt_q + CNT_W'(1);
    cap_all     = captured_q | mic_valid_in;

    for (int i = 0; i < 3; i++) begin
      if (mic_valid_in[i]) slot_d[i] = mic_data[i];
    end

    case (state_q)
      ST_IDLE, ST_EMIT: begin
        push       = (state_q == ST_EMIT);
        captured_d = mic_valid_in;
        cnt_d      = '0;
        set_skew_d = '0;
        if (&mic_valid_in)      state_d = ST_EMIT;
        else if (|mic_valid_in) state_d = ST_COLLECT;
        else                    state_d = ST_IDLE;
      end
      ST_COLLECT: begin
        dup_set = |(captured_q & mic_valid_in);
        cnt_d   = cnt_inc;
        if (&cap_all) begin
          captured_d = cap_all;
          state_d    = ST_EMIT;
          if (int'(cnt_inc) > SKEW_MAX_I) set_skew_d = SKEW_W'(SKEW_MAX_I);
          else                            set_skew_d = SKEW_W'(cnt_inc);
        end else if (cnt_inc >= TIMEOUT_LAST) begin
          captured_d  = '0;
          cnt_d       = '0;
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          captured_d = cap_all;
        end
      end
      default: begin
        captured_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Output FIFO: a push into a full FIFO only lands if the head leaves this cycle.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_d     = wr_q;
    rd_d     = rd_q;
    fill_d   = fill_q;
    pop      = (fill_q != '0) && out_ready_in;
    full     = (fill_q == FILL_W'(FIFO_DEPTH));
    do_push  = push && (!full || pop);
    drop_set = push && full && !pop;

    if (do_push) begin
      mem_d[wr_q] = {slot_q[0], slot_q[1], slot_q[2], set_skew_q};
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);

    if (do_push && !pop)      fill_d = fill_q + FILL_W'(1);
    else if (!do_push && pop) fill_d = fill_q - FILL_W'(1);
  end

  always_comb begin
    timeout_d = timeout_set ? 1'b1 : (clear_flags_in ? 1'b0 : timeout_q);
    dup_d     = dup_set     ? 1'b1 : (clear_flags_in ? 1'b0 : dup_q);
    drop_d    = drop_set    ? 1'b1 : (clear_flags_in ? 1'b0 : drop_q);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      captured_q <= '0;
      set_skew_q <= '0;
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fill_q     <= '0;
      timeout_q  <= 1'b0;
      dup_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      set_skew_q <= set_skew_d;
      for (int i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fill_q     <= fill_d;
      timeout_q  <= timeout_d;
      dup_q      <= dup_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid_out    = (fill_q != '0);
  assign out_data_0_out   = mem_q[rd_q][E_W-1 -: WIDTH];
  assign out_data_1_out   = mem_q[rd_q][E_W-WIDTH-1 -: WIDTH];
  assign out_data_2_out   = mem_q[rd_q][SKEW_W +: WIDTH];
  assign out_skew_out     = mem_q[rd_q][SKEW_W-1:0];
  assign fill_out         = fill_q;
  assign timeout_flag_out = timeout_q;
  assign dup_flag_out     = dup_q;
  assign drop_flag_out    = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_mic_triplet_aligner.sv
// +----------------------------------------------------------------------------+
// | tb_mic_triplet_aligner: directed self-checking bench for the aligner.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mic_triplet_aligner;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int SKW   = 12;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [2:0]       mic_valid_in;
  logic [WIDTH-1:0] d0, d1, d2;
  logic             clear_flags_in;
  logic             out_ready_in;
  logic             out_valid_out;
  logic [WIDTH-1:0] q0, q1, q2;
  logic [SKW-1:0]   skew;
  logic [2:0]       fill;
  logic             tmo_f, dup_f, drop_f;

  int n_cmp = 0;
  int n_err = 0;

  mic_triplet_aligner #(
    .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SKEW_W(SKW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mic_valid_in(mic_valid_in),
    .mic_data_0_in(d0), .mic_data_1_in(d1), .mic_data_2_in(d2),
    .clear_flags_in(clear_flags_in), .out_ready_in(out_ready_in),
    .out_valid_out(out_valid_out),
    .out_data_0_out(q0), .out_data_1_out(q1), .out_data_2_out(q2),
    .out_skew_out(skew), .fill_out(fill),
    .timeout_flag_out(tmo_f), .dup_flag_out(dup_f), .drop_flag_out(drop_f)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic head(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2, input logic [11:0] es);
    check_eq({tag, ".valid"}, 32'(out_valid_out), 32'd1);
    check_eq({tag, ".d0"}, 32'(q0), 32'(e0));
    check_eq({tag, ".d1"}, 32'(q1), 32'(e1));
    check_eq({tag, ".d2"}, 32'(q2), 32'(e2));
    check_eq({tag, ".skew"}, 32'(skew), 32'(es));
  endtask

  task automatic clear_flags();
    clear_flags_in = 1'b1;
    tick();
    clear_flags_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; mic_valid_in = '0; d0 = '0; d1 = '0; d2 = '0;
    clear_flags_in = 1'b0; out_ready_in = 1'b1;
    #12;
    check_eq("rst.valid", 32'(out_valid_out), 32'd0);
    check_eq("rst.fill", 32'(fill), 32'd0);
    check_eq("rst.flags", 32'({tmo_f, dup_f, drop_f}), 32'd0);
    check_eq("rst.data", 32'({q0, q1}), 32'd0);
    rst_in = 1'b1;
    tick();

    // 1: all three together, two-cycle latency, one-cycle output
    mic_valid_in = 3'b111; d0 = 16'h1111; d1 = 16'h2222; d2 = 16'h3333;
    tick();
    mic_valid_in = '0;
    check_eq("t1.lat1", 32'(out_valid_out), 32'd0);
    tick();
    head("t1", 16'h1111, 16'h2222, 16'h3333, 12'd0);
    check_eq("t1.fill1", 32'(fill), 32'd1);
    tick();
    check_eq("t1.gone", 32'(out_valid_out), 32'd0);
    check_eq("t1.fill0", 32'(fill), 32'd0);

    // 2: staggered arrivals at t, t+5, t+10
    mic_valid_in = 3'b001; d0 = 16'h00A0;
    tick();
    mic_valid_in = '0; tick(4);
    mic_valid_in = 3'b010; d1 = 16'h00B1;
    tick();
    mic_valid_in = '0; tick(4);
    mic_valid_in = 3'b100; d2 = 16'h00C2;
    tick();
    mic_valid_in = '0;
    check_eq("t2.lat1", 32'(out_valid_out), 32'd0);
    tick();
    head("t2", 16'h00A0, 16'h00B1, 16'h00C2, 12'd10);
    check_eq("t2.flags", 32'({tmo_f, dup_f, drop_f}), 32'd0);
    tick();

    // 3: duplicate mic0 overwrites, skew from the first capture
    mic_valid_in = 3'b001; d0 = 16'h0001;
    tick();
    mic_valid_in = '0; tick(2);
    mic_valid_in = 3'b001; d0 = 16'h0002;
    tick();
    mic_valid_in = 3'b010; d1 = 16'h0D01;
    tick();
    mic_valid_in = '0; tick();
    mic_valid_in = 3'b100; d2 = 16'h0D02;
    tick();
    mic_valid_in = '0; tick();
    head("t3", 16'h0002, 16'h0D01, 16'h0D02, 12'd6);
    check_eq("t3.dup", 32'(dup_f), 32'd1);
    tick();
    clear_flags();
    check_eq("t3.dupclr", 32'(dup_f), 32'd0);

    // 4a: completion at offset TMO-2 still emits
    mic_valid_in = 3'b001; d0 = 16'h4A00;
    tick();
    mic_valid_in = '0; tick(13);
    mic_valid_in = 3'b110; d1 = 16'h4A01; d2 = 16'h4A02;
    tick();
    mic_valid_in = '0; tick();
    head("t4a", 16'h4A00, 16'h4A01, 16'h4A02, 12'd14);
    check_eq("t4a.tmo", 32'(tmo_f), 32'd0);
    tick();

    // 4b: lone mic0 times out
    mic_valid_in = 3'b001; d0 = 16'h4B00;
    tick();
    mic_valid_in = '0; tick(14);
    check_eq("t4b.pre", 32'(tmo_f), 32'd0);
    tick();
    check_eq("t4b.tmo", 32'(tmo_f), 32'd1);
    check_eq("t4b.noout", 32'(out_valid_out), 32'd0);
    mic_valid_in = 3'b111; d0 = 16'h4C00; d1 = 16'h4C01; d2 = 16'h4C02;
    tick();
    mic_valid_in = '0; tick();
    head("t4b.next", 16'h4C00, 16'h4C01, 16'h4C02, 12'd0);
    tick();
    clear_flags();
    check_eq("t4b.clr", 32'(tmo_f), 32'd0);

    // 5: five back-to-back sets into a 4-deep FIFO with ready low
    out_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mic_valid_in = 3'b111;
      d0 = 16'h5000 + 16'(i); d1 = 16'h6000 + 16'(i); d2 = 16'h7000 + 16'(i);
      tick();
    end
    mic_valid_in = '0;
    tick();
    check_eq("t5.fill", 32'(fill), 32'd4);
    check_eq("t5.drop", 32'(drop_f), 32'd1);
    head("t5.hold0", 16'h5000, 16'h6000, 16'h7000, 12'd0);
    tick();
    head("t5.hold1", 16'h5000, 16'h6000, 16'h7000, 12'd0);
    out_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head($sformatf("t5.pop%0d", i), 16'h5000 + 16'(i), 16'h6000 + 16'(i),
           16'h7000 + 16'(i), 12'd0);
      tick();
    end
    check_eq("t5.empty", 32'(out_valid_out), 32'd0);
    check_eq("t5.fill0", 32'(fill), 32'd0);
    clear_flags();
    check_eq("t5.dropclr", 32'(drop_f), 32'd0);

    // 6: asynchronous reset with queued triplets and an open set
    out_ready_in = 1'b0;
    mic_valid_in = 3'b111; d0 = 16'h0A00; d1 = 16'h0A01; d2 = 16'h0A02;
    tick();
    d0 = 16'h0B00; d1 = 16'h0B01; d2 = 16'h0B02;
    tick();
    mic_valid_in = 3'b011;
    tick();
    mic_valid_in = 3'b001;
    tick();
    mic_valid_in = '0;
    check_eq("t6.prefill", 32'(fill), 32'd2);
    check_eq("t6.predup", 32'(dup_f), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check_eq("t6.valid", 32'(out_valid_out), 32'd0);
    check_eq("t6.fill", 32'(fill), 32'd0);
    check_eq("t6.flags", 32'({tmo_f, dup_f, drop_f}), 32'd0);
    #4 rst_in = 1'b1;
    tick();
    out_ready_in = 1'b1;
    mic_valid_in = 3'b100; d2 = 16'h0E02;
    tick();
    mic_valid_in = '0; tick(2);
    mic_valid_in = 3'b011; d0 = 16'h0E00; d1 = 16'h0E01;
    tick();
    mic_valid_in = '0; tick();
    head("t6.fresh", 16'h0E00, 16'h0E01, 16'h0E02, 12'd3);
    check_eq("t6.fill1", 32'(fill), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
